hazard_ctrl: RTL and testbench

Issue/hazard controller between fetch/decode and the register-read decoder stage of the in-order RV32I pipeline. Holds a 32-entry pending-write scoreboard and an in-flight instruction counter. Stalls decode on RAW/WAW hazards and control-flow instructions, then flushes the front end after a taken redirect. Sequences the pipeline; does not decode immediates or select ALU operands.

---
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// RV32I issue/hazard controller: pending-write scoreboard, in-flight limit, branch sequencing.
// Optional: define WB_BYPASS_EN to treat a register retiring this cycle as not busy.
module hazard_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             retire_valid,
  input  logic             ctrl_resolve,
  input  logic             ctrl_taken,
  output logic             id_ready,
  output logic             issue,
  output logic             fetch_hold,
  output logic             flush,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] inflight,
  output logic             err
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic        use_rs1, use_rs2, wr_rd, is_ctrl;
  logic [31:0] clr_vec, set_vec, busy_chk;
  logic        raw_haz, waw_haz, room;
  logic        retire_ok, underflow, bad_resolve;
  logic        unused_bits;

  assign opcode      = id_inst[6:0];
  assign rd          = id_inst[11:7];
  assign rs1         = id_inst[19:15];
  assign rs2         = id_inst[24:20];
  assign unused_bits = ^{id_inst[31:25], id_inst[14:12]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    is_ctrl = 1'b0;
    unique case (opcode)
      OP_OPIMM:  begin use_rs1 = 1'b1; wr_rd = 1'b1; end
      OP_OP:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
      OP_LUI:    wr_rd = 1'b1;
      OP_AUIPC:  wr_rd = 1'b1;
      OP_JAL:    begin wr_rd = 1'b1; is_ctrl = 1'b1; end
      OP_JALR:   begin use_rs1 = 1'b1; wr_rd = 1'b1; is_ctrl = 1'b1; end
      OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_ctrl = 1'b1; end
      OP_LOAD:   begin use_rs1 = 1'b1; wr_rd = 1'b1; end
      OP_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default:   ;
    endcase
  end

  assign clr_vec = (wb_valid && wb_rd != 5'd0) ? (32'd1 << wb_rd) : 32'd0;

`ifdef WB_BYPASS_EN
  assign busy_chk = busy_q & ~clr_vec;
`else
  assign busy_chk = busy_q;
`endif

  assign raw_haz = (use_rs1 && rs1 != 5'd0 && busy_chk[rs1])
                 | (use_rs2 && rs2 != 5'd0 && busy_chk[rs2]);
  assign waw_haz = wr_rd && rd != 5'd0 && busy_chk[rd];
  assign room    = inflight_q < CNT_W'(MAX_INFLIGHT);

  assign id_ready = (state_q == S_RUN) && room && !raw_haz && !waw_haz;
  assign issue    = id_valid && id_ready;

  // Set is ORed in after the clear so a same-edge set wins.
  assign set_vec = (issue && wr_rd && rd != 5'd0) ? (32'd1 << rd) : 32'd0;
  assign busy_d  = (busy_q & ~clr_vec) | set_vec;

  assign retire_ok   = retire_valid && inflight_q != '0;
  assign underflow   = retire_valid && inflight_q == '0;
  assign bad_resolve = ctrl_resolve && state_q != S_WAIT;
  assign err_d       = err_q | underflow | bad_resolve;

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !retire_ok)
      inflight_d = inflight_q + CNT_W'(1);
    else if (!issue && retire_ok)
      inflight_d = inflight_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (issue && is_ctrl) state_d = S_WAIT;
      S_WAIT:  if (ctrl_resolve)
                 state_d = ctrl_taken ? S_FLUSH : S_RUN;
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_RUN;
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign fetch_hold = (state_q == S_WAIT);
  assign flush      = (state_q == S_FLUSH);
  assign busy_mask  = busy_q;
  assign inflight   = inflight_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Build with +define+WB_BYPASS_EN to check the writeback-bypass variant.
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        retire_valid;
  logic        ctrl_resolve;
  logic        ctrl_taken;
  logic        id_ready;
  logic        issue;
  logic        fetch_hold;
  logic        flush;
  logic [31:0] busy_mask;
  logic [3:0]  inflight;
  logic        err;

  int checks   = 0;
  int failures = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  hazard_ctrl #(.MAX_INFLIGHT(4), .CNT_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_inst      (id_inst),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .retire_valid (retire_valid),
    .ctrl_resolve (ctrl_resolve),
    .ctrl_taken   (ctrl_taken),
    .id_ready     (id_ready),
    .issue        (issue),
    .fetch_hold   (fetch_hold),
    .flush        (flush),
    .busy_mask    (busy_mask),
    .inflight     (inflight),
    .err          (err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [6:0] op,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] STORE  = 7'b0100011;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_inst      = 32'd0;
    wb_valid     = 1'b0;
    wb_rd        = 5'd0;
    retire_valid = 1'b0;
    ctrl_resolve = 1'b0;
    ctrl_taken   = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (busy_mask !== 32'd0) begin
      $display("FAIL reset_busy got=%h exp=%h", busy_mask, 32'd0);
      failures++;
    end
    checks++;
    if ({inflight, flush, fetch_hold, err} !== 7'b0000_000) begin
      $display("FAIL reset_state got=%b exp=%b",
               {inflight, flush, fetch_hold, err}, 7'b0);
      failures++;
    end
    checks++;
    if (id_ready !== 1'b1) begin
      $display("FAIL reset_ready got=%b exp=1", id_ready);
      failures++;
    end
  endtask

  task automatic test_raw();
    id_valid = 1'b1;
    id_inst  = mk(OPIMM, 5'd5, 5'd0, 5'd0);
    #1;
    checks++;
    if (issue !== 1'b1) begin
      $display("FAIL addi_issue got=%b exp=1", issue);
      failures++;
    end
    tick();
    id_inst = mk(OPR, 5'd6, 5'd5, 5'd5);
    #1;
    checks++;
    if (busy_mask !== 32'h20 || inflight !== 4'd1) begin
      $display("FAIL addi_sb got=%h/%0d exp=00000020/1", busy_mask, inflight);
      failures++;
    end
    checks++;
    if (id_ready !== 1'b0) begin
      $display("FAIL raw_block got=%b exp=0", id_ready);
      failures++;
    end
    tick();
    checks++;
    if (id_ready !== 1'b0) begin
      $display("FAIL raw_block2 got=%b exp=0", id_ready);
      failures++;
    end
    wb_valid     = 1'b1;
    wb_rd        = 5'd5;
    retire_valid = 1'b1;
    #1;
    checks++;
    if (id_ready !== BYP) begin
      $display("FAIL wb_cycle_ready got=%b exp=%b", id_ready, BYP);
      failures++;
    end
    tick();
    wb_valid     = 1'b0;
    retire_valid = 1'b0;
    if (!BYP) begin
      #1;
      checks++;
      if (id_ready !== 1'b1 || busy_mask !== 32'd0) begin
        $display("FAIL raw_release got=%b/%h exp=1/00000000", id_ready, busy_mask);
        failures++;
      end
      tick();
    end
    id_valid = 1'b0;
    #1;
    checks++;
    if (busy_mask !== 32'h40 || inflight !== 4'd1) begin
      $display("FAIL add_sb got=%h/%0d exp=00000040/1", busy_mask, inflight);
      failures++;
    end
    wb_valid     = 1'b1;
    wb_rd        = 5'd6;
    retire_valid = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (busy_mask !== 32'd0 || inflight !== 4'd0) begin
      $display("FAIL add_retire got=%h/%0d exp=00000000/0", busy_mask, inflight);
      failures++;
    end
  endtask

  task automatic test_set_wins();
    id_valid = 1'b1;
    id_inst  = mk(OPIMM, 5'd7, 5'd0, 5'd0);
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    tick();
    idle();
    #1;
    checks++;
    if (busy_mask !== 32'h80 || inflight !== 4'd1) begin
      $display("FAIL set_wins got=%h/%0d exp=00000080/1", busy_mask, inflight);
      failures++;
    end
    wb_valid     = 1'b1;
    wb_rd        = 5'd7;
    retire_valid = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_branch_taken();
    id_valid = 1'b1;
    id_inst  = mk(BRANCH, 5'd0, 5'd1, 5'd2);
    #1;
    checks++;
    if (issue !== 1'b1) begin
      $display("FAIL beq_issue got=%b exp=1", issue);
      failures++;
    end
    tick();
    id_inst = mk(OPIMM, 5'd3, 5'd0, 5'd0);
    #1;
    checks++;
    if ({fetch_hold, id_ready, flush} !== 3'b100 || inflight !== 4'd1) begin
      $display("FAIL beq_wait got=%b/%0d exp=100/1",
               {fetch_hold, id_ready, flush}, inflight);
      failures++;
    end
    id_valid     = 1'b0;
    ctrl_resolve = 1'b1;
    ctrl_taken   = 1'b1;
    retire_valid = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if ({flush, fetch_hold, id_ready} !== 3'b100 || inflight !== 4'd0) begin
      $display("FAIL beq_flush got=%b/%0d exp=100/0",
               {flush, fetch_hold, id_ready}, inflight);
      failures++;
    end
    tick();
    checks++;
    if ({flush, fetch_hold, id_ready, err} !== 4'b0010) begin
      $display("FAIL beq_run got=%b exp=0010", {flush, fetch_hold, id_ready, err});
      failures++;
    end
  endtask

  task automatic test_jal_not_taken();
    id_valid = 1'b1;
    id_inst  = mk(JAL, 5'd1, 5'd0, 5'd0);
    tick();
    id_valid = 1'b0;
    #1;
    checks++;
    if (fetch_hold !== 1'b1 || busy_mask !== 32'h2) begin
      $display("FAIL jal_wait got=%b/%h exp=1/00000002", fetch_hold, busy_mask);
      failures++;
    end
    ctrl_resolve = 1'b1;
    ctrl_taken   = 1'b0;
    tick();
    idle();
    #1;
    checks++;
    if ({flush, fetch_hold} !== 2'b00 || busy_mask !== 32'h2) begin
      $display("FAIL jal_nt got=%b/%h exp=00/00000002", {flush, fetch_hold}, busy_mask);
      failures++;
    end
    tick();
    checks++;
    if (flush !== 1'b0 || busy_mask !== 32'h2) begin
      $display("FAIL jal_noflush got=%b/%h exp=0/00000002", flush, busy_mask);
      failures++;
    end
    wb_valid     = 1'b1;
    wb_rd        = 5'd1;
    retire_valid = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if (busy_mask !== 32'd0 || inflight !== 4'd0 || err !== 1'b0) begin
      $display("FAIL jal_retire got=%h/%0d/%b exp=00000000/0/0", busy_mask, inflight, err);
      failures++;
    end
  endtask

  task automatic test_inflight_limit();
    id_valid = 1'b1;
    id_inst  = mk(STORE, 5'd0, 5'd2, 5'd3);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (issue !== 1'b1) begin
        $display("FAIL sw_issue%0d got=%b exp=1", i, issue);
        failures++;
      end
      tick();
    end
    #1;
    checks++;
    if (inflight !== 4'd4 || id_ready !== 1'b0) begin
      $display("FAIL sw_full got=%0d/%b exp=4/0", inflight, id_ready);
      failures++;
    end
    retire_valid = 1'b1;
    #1;
    checks++;
    if (issue !== 1'b0) begin
      $display("FAIL sw_full_issue got=%b exp=0", issue);
      failures++;
    end
    tick();
    checks++;
    if (inflight !== 4'd3 || issue !== 1'b1) begin
      $display("FAIL sw_both got=%0d/%b exp=3/1", inflight, issue);
      failures++;
    end
    tick();
    retire_valid = 1'b0;
    #1;
    checks++;
    if (inflight !== 4'd3) begin
      $display("FAIL sw_hold got=%0d exp=3", inflight);
      failures++;
    end
    tick();
    id_valid     = 1'b0;
    retire_valid = 1'b1;
    #1;
    checks++;
    if (inflight !== 4'd4) begin
      $display("FAIL sw_refill got=%0d exp=4", inflight);
      failures++;
    end
    for (int i = 0; i < 4; i++) tick();
    idle();
    #1;
    checks++;
    if (inflight !== 4'd0 || err !== 1'b0) begin
      $display("FAIL sw_drain got=%0d/%b exp=0/0", inflight, err);
      failures++;
    end
  endtask

  task automatic test_err();
    ctrl_resolve = 1'b1;
    ctrl_taken   = 1'b1;
    tick();
    idle();
    #1;
    checks++;
    if ({err, fetch_hold, flush, id_ready} !== 4'b1001) begin
      $display("FAIL resolve_run got=%b exp=1001", {err, fetch_hold, flush, id_ready});
      failures++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    retire_valid = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin
      $display("FAIL err_clear got=%b exp=0", err);
      failures++;
    end
    tick();
    idle();
    #1;
    checks++;
    if (err !== 1'b1 || inflight !== 4'd0) begin
      $display("FAIL underflow got=%b/%0d exp=1/0", err, inflight);
      failures++;
    end
    tick();
    tick();
    checks++;
    if (err !== 1'b1) begin
      $display("FAIL err_sticky got=%b exp=1", err);
      failures++;
    end
  endtask

  task automatic test_reset_in_wait();
    id_valid = 1'b1;
    id_inst  = mk(OPIMM, 5'd9, 5'd0, 5'd0);
    tick();
    id_inst = mk(BRANCH, 5'd0, 5'd1, 5'd2);
    tick();
    idle();
    #1;
    checks++;
    if (fetch_hold !== 1'b1 || busy_mask !== 32'h200 || inflight !== 4'd2) begin
      $display("FAIL pre_reset got=%b/%h/%0d exp=1/00000200/2",
               fetch_hold, busy_mask, inflight);
      failures++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({fetch_hold, flush, err, id_ready} !== 4'b0001 ||
        busy_mask !== 32'd0 || inflight !== 4'd0) begin
      $display("FAIL wait_reset got=%b/%h/%0d exp=0001/00000000/0",
               {fetch_hold, flush, err, id_ready}, busy_mask, inflight);
      failures++;
    end
    tick();
    checks++;
    if (fetch_hold !== 1'b0 || flush !== 1'b0) begin
      $display("FAIL wait_abandon got=%b exp=00", {fetch_hold, flush});
      failures++;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_set_wins();
    test_branch_taken();
    test_jal_not_taken();
    test_inflight_limit();
    test_err();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
